// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI read scheduler.
//   sched_state_t   : scheduler FSM state encoding
//   AXI_BURST_INCR  : ARBURST value for incrementing bursts
//   AXI_RESP_OKAY   : RRESP value for a good beat
//   AXI_4K_BYTES    : AXI page size that a burst must not cross
//   clog2_min1      : index width helper, never returns 0
//   beat_lsb        : log2 of bytes per data beat
package axi_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } sched_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K_BYTES   = 4096;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int beat_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   advance    : commit the current grant; pointer moves past the winner
//   grant      : one-hot grant (zero when no request)
//   grant_idx  : binary index of the granted requester
// After reset requester 0 has the highest priority.
module rr_arbiter
    import axi_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = clog2_min1(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;
    logic             found;

    // Scan starting at the pointer, wrapping at NUM_REQ; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_scheduler.sv
// Shares one AXI4 read port among NUM_REQ loaders. Each loader posts a whole
// transfer (start address, beat count); the scheduler arbitrates round-robin,
// cuts the transfer into INCR bursts (one outstanding) and steers R beats to
// the owner.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/ready     : per-loader transfer handshake (ready is one-hot)
//   req_addr/req_beats  : packed per-loader start address and beat count
//   rd_data/valid/last  : beat data to the owner; rd_last marks transfer end
//   rd_ready            : per-loader beat accept
//   rresp_err           : sticky, set by any beat with RRESP != OKAY
//   m_axi_ar*/m_axi_r*  : AXI4 read address / read data channels
// Build option: AXI_RD_SCHED_4K_SPLIT_EN additionally stops bursts at 4 KB
// boundaries.
//
// state   | meaning
// IDLE    | arbitrating; req_ready shows the one-hot grant
// ADDR    | driving AR for the next burst of the owner's transfer
// DATA    | passing R beats of the current burst to the owner
module axi_rd_scheduler
    import axi_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 8,
    parameter int MAX_BURST   = 256,
    parameter int BEATS_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*BEATS_WIDTH-1:0] req_beats,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic                           rd_last,
    input  logic [NUM_REQ-1:0]             rd_ready,
    output logic                           rresp_err,
    output logic [ID_WIDTH-1:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [ID_WIDTH-1:0]            m_axi_rid,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    localparam int IDX_W          = clog2_min1(NUM_REQ);
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int ADDR_LSB       = beat_lsb(DATA_WIDTH);

    sched_state_t           state, state_nxt;
    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [ADDR_WIDTH-1:0]  addr, addr_nxt;
    logic [BEATS_WIDTH-1:0] remaining, remaining_nxt;
    logic                   rresp_err_nxt;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [BEATS_WIDTH-1:0] sel_beats;
    logic [8:0]             burst_max;
    logic [8:0]             burst;
    logic                   r_hs;
    logic                   unused_rid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (state == ST_IDLE),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Start address is forced onto a beat boundary.
    assign sel_addr  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                     & ~ADDR_WIDTH'(BYTES_PER_BEAT - 1);
    assign sel_beats = req_beats[int'(grant_idx)*BEATS_WIDTH +: BEATS_WIDTH];

    assign rd_data       = m_axi_rdata;
    assign m_axi_arsize  = 3'(ADDR_LSB);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign unused_rid    = ^m_axi_rid;

    always_comb begin
        if (32'(remaining) > 32'(MAX_BURST)) begin
            burst_max = 9'(MAX_BURST);
        end else begin
            burst_max = 9'(remaining);
        end
    end

`ifdef AXI_RD_SCHED_4K_SPLIT_EN
    // Beats left before the next 4 KB page; never zero since addr is beat aligned.
    logic [12:0] room_beats;
    always_comb begin
        room_beats = (13'(AXI_4K_BYTES) - {1'b0, addr[11:0]}) >> ADDR_LSB;
        burst      = burst_max;
        if ({4'b0, burst_max} > room_beats) begin
            burst = room_beats[8:0];
        end
    end
`else
    assign burst = burst_max;
`endif

    assign r_hs = (state == ST_DATA) && m_axi_rvalid && rd_ready[owner];

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        rresp_err_nxt = rresp_err;
        req_ready     = '0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arid    = '0;
        m_axi_rready  = 1'b0;
        rd_valid      = '0;
        rd_last       = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (|req_valid) begin
                    owner_nxt     = grant_idx;
                    addr_nxt      = sel_addr;
                    remaining_nxt = sel_beats;
                    // A zero-length request is acknowledged without AXI traffic.
                    if (sel_beats != '0) begin
                        state_nxt = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = addr;
                m_axi_arlen   = 8'(burst - 9'd1);
                m_axi_arid    = ID_WIDTH'(owner);
                if (m_axi_arready) begin
                    state_nxt = ST_DATA;
                end
            end

            ST_DATA: begin
                m_axi_rready    = rd_ready[owner];
                rd_valid[owner] = m_axi_rvalid;
                rd_last         = m_axi_rvalid && (remaining == BEATS_WIDTH'(1));
                if (r_hs) begin
                    remaining_nxt = remaining - 1'b1;
                    addr_nxt      = addr + ADDR_WIDTH'(BYTES_PER_BEAT);
                    if (m_axi_rresp != AXI_RESP_OKAY) begin
                        rresp_err_nxt = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        state_nxt = (remaining != BEATS_WIDTH'(1)) ? ST_ADDR : ST_IDLE;
                    end
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= '0;
            addr      <= '0;
            remaining <= '0;
            rresp_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            rresp_err <= rresp_err_nxt;
        end
    end

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Randomised bench for axi_rd_scheduler with a transfer-level reference model
// (expected AR list and expected beat list per accepted transfer) and a
// simple one-outstanding AXI read slave.
module tb_axi_rd_scheduler;

    localparam int NUM_REQ = 2;
    localparam int DW      = 512;
    localparam int AW      = 32;
    localparam int IW      = 8;
    localparam int BW      = 16;
`ifdef AXI_RD_SCHED_4K_SPLIT_EN
    localparam bit SPLIT4K = 1'b1;
`else
    localparam bit SPLIT4K = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*BW-1:0] req_beats;
    logic [DW-1:0]         rd_data;
    logic [NUM_REQ-1:0]    rd_valid;
    logic                  rd_last;
    logic [NUM_REQ-1:0]    rd_ready;
    logic                  rresp_err;
    logic [IW-1:0]         m_axi_arid;
    logic [AW-1:0]         m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [IW-1:0]         m_axi_rid;
    logic [DW-1:0]         m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    always #5 clk = ~clk;

    axi_rd_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_beats     (req_beats),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .rd_ready      (rd_ready),
        .rresp_err     (rresp_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    typedef struct { int unsigned addr; int beats; } xfer_t;
    typedef struct { int unsigned addr; int len; int id; } ar_t;
    typedef struct { int unsigned addr; bit last; } beat_t;

    int n_checks = 0;
    int n_errors = 0;

    xfer_t pend[NUM_REQ][$];
    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    int    accept_log[$];

    int          rr_ptr, cur_owner, ar_count, hold_rdy0;
    bit          busy, model_err;
    bit          s_active, s_start, s_consumed, err_en;
    int unsigned s_addr, s_ar_addr, err_addr;
    int          s_left, s_ar_len;
    int          ar_pct = 60, rv_pct = 70, rdy_pct = 75;

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    endtask

    function automatic logic [DW-1:0] data_of(input int unsigned a);
        logic [31:0] w;
        w = a ^ 32'h5A5A_0000;
        return {16{w}};
    endfunction

    // Expected bursts and beats for one accepted transfer.
    task automatic expect_xfer(input int id, input int unsigned addr0, input int beats);
        int unsigned a;
        int rem, b, room;
        a = addr0 & 32'hFFFF_FFC0;
        for (int k = 0; k < beats; k++) begin
            exp_beat.push_back('{a + 64 * k, k == beats - 1});
        end
        rem = beats;
        while (rem > 0) begin
            b = (rem > 256) ? 256 : rem;
            if (SPLIT4K) begin
                room = (4096 - int'(a % 4096)) / 64;
                if (b > room) b = room;
            end
            exp_ar.push_back('{a, b - 1, id});
            a   = a + 64 * b;
            rem = rem - b;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
        exp_ar.delete();
        exp_beat.delete();
        busy = 0; rr_ptr = 0; model_err = 0; cur_owner = 0;
        s_active = 0; s_start = 0; s_consumed = 0; hold_rdy0 = 0;
        req_valid = '0; rd_ready = '0; m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'd0;
        m_axi_rdata = '0; m_axi_rid = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pend[i].size() > 0) begin
                req_valid[i]          = 1'b1;
                req_addr[i*AW +: AW]  = pend[i][0].addr;
                req_beats[i*BW +: BW] = BW'(pend[i][0].beats);
            end else begin
                req_valid[i]          = 1'b0;
                req_addr[i*AW +: AW]  = $urandom;
                req_beats[i*BW +: BW] = BW'($urandom);
            end
            rd_ready[i] = ($urandom % 100) < rdy_pct;
        end
        if (hold_rdy0 > 0) begin
            rd_ready[0] = 1'b0;
            hold_rdy0--;
        end
        m_axi_arready = ($urandom % 100) < ar_pct;
        if (s_start) begin
            s_start  = 0;
            s_active = 1;
            s_addr   = s_ar_addr;
            s_left   = s_ar_len + 1;
        end
        if (s_consumed) begin
            s_consumed   = 0;
            m_axi_rvalid = 1'b0;
            s_addr       = s_addr + 64;
            s_left--;
            if (s_left == 0) s_active = 0;
        end
        if (s_active && !m_axi_rvalid && (($urandom % 100) < rv_pct)) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = data_of(s_addr);
            m_axi_rresp  = (err_en && s_addr == err_addr) ? 2'd2 : 2'd0;
            m_axi_rlast  = (s_left == 1);
            m_axi_rid    = IW'($urandom);
        end
    endtask

    task automatic sample();
        int pick, idx;
        logic [NUM_REQ-1:0] exp_rdy, exp_rv;
        xfer_t x;
        ar_t   e;
        beat_t b;
        pick = -1;
        if (!busy) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (rr_ptr + k) % NUM_REQ;
                if (pick < 0 && req_valid[idx]) pick = idx;
            end
            check_val("arvalid_idle", DW'(m_axi_arvalid), DW'(0));
        end
        exp_rdy = (pick >= 0) ? (NUM_REQ'(1) << pick) : '0;
        check_val("req_ready", DW'(req_ready), DW'(exp_rdy));
        if (pick >= 0) begin
            x = pend[pick].pop_front();
            accept_log.push_back(pick);
            rr_ptr = (pick + 1) % NUM_REQ;
            if (x.beats > 0) begin
                busy      = 1;
                cur_owner = pick;
            end
            expect_xfer(pick, x.addr, x.beats);
        end

        if (m_axi_arvalid && m_axi_arready) begin
            ar_count++;
            check_val("ar_pending", DW'(exp_ar.size() > 0), DW'(1));
            if (exp_ar.size() > 0) begin
                e = exp_ar.pop_front();
                check_val("araddr", DW'(m_axi_araddr), DW'(e.addr));
                check_val("arlen", DW'(m_axi_arlen), DW'(e.len));
                check_val("arid", DW'(m_axi_arid), DW'(e.id));
                check_val("arsize", DW'(m_axi_arsize), DW'(6));
                check_val("arburst", DW'(m_axi_arburst), DW'(1));
            end
            s_start   = 1;
            s_ar_addr = m_axi_araddr;
            s_ar_len  = int'(m_axi_arlen);
        end

        check_val("m_rready", DW'(m_axi_rready), DW'(s_active ? rd_ready[cur_owner] : 1'b0));
        exp_rv = (s_active && m_axi_rvalid) ? (NUM_REQ'(1) << cur_owner) : '0;
        check_val("rd_valid", DW'(rd_valid), DW'(exp_rv));
        check_val("rresp_err", DW'(rresp_err), DW'(model_err));

        if (s_active && m_axi_rvalid) begin
            check_val("beat_pending", DW'(exp_beat.size() > 0), DW'(1));
            if (exp_beat.size() > 0) begin
                check_val("rd_last", DW'(rd_last), DW'(exp_beat[0].last));
                if (m_axi_rready) begin
                    b = exp_beat.pop_front();
                    check_val("rd_data", rd_data, data_of(b.addr));
                    if (b.last) busy = 0;
                end
            end
            if (m_axi_rready) begin
                s_consumed = 1;
                if (m_axi_rresp != 2'd0) model_err = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    function automatic bit model_idle();
        int n;
        n = 0;
        for (int i = 0; i < NUM_REQ; i++) n += pend[i].size();
        return (n == 0) && !busy && !s_active && !s_start
               && exp_ar.size() == 0 && exp_beat.size() == 0;
    endfunction

    task automatic drain();
        int cyc;
        cyc = 0;
        while (!model_idle() && cyc < 20000) begin
            cycle();
            cyc++;
        end
        if (!model_idle()) begin
            check_val("drain_done", DW'(model_idle()), DW'(1));
            finish_sim();
        end
        repeat (2) cycle();
    endtask

    task automatic wait_beats_left(input int left);
        int cyc;
        cyc = 0;
        while (!(s_active && exp_beat.size() <= left) && cyc < 5000) begin
            cycle();
            cyc++;
        end
        if (!(s_active && exp_beat.size() <= left)) begin
            check_val("mid_burst_reached", DW'(exp_beat.size() <= left), DW'(1));
            finish_sim();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, DW'(req_ready), DW'(0));
        check_val({tag, "_arvalid"}, DW'(m_axi_arvalid), DW'(0));
        check_val({tag, "_araddr"}, DW'(m_axi_araddr), DW'(0));
        check_val({tag, "_arlen"}, DW'(m_axi_arlen), DW'(0));
        check_val({tag, "_arid"}, DW'(m_axi_arid), DW'(0));
        check_val({tag, "_rready"}, DW'(m_axi_rready), DW'(0));
        check_val({tag, "_rd_valid"}, DW'(rd_valid), DW'(0));
        check_val({tag, "_rd_last"}, DW'(rd_last), DW'(0));
        check_val({tag, "_rresp_err"}, DW'(rresp_err), DW'(0));
    endtask

    initial begin
        req_addr = '0;
        req_beats = '0;
        err_en = 0;
        err_addr = 0;
        ar_count = 0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single short transfer
        ar_count = 0;
        pend[0].push_back('{32'h1000, 4});
        drain();
        check_val("t1_ar_count", DW'(ar_count), DW'(1));

        // long transfer split into bursts
        ar_count = 0;
        pend[1].push_back('{32'h0, 600});
        drain();
        check_val("t2_ar_count", DW'(ar_count), DW'(SPLIT4K ? 10 : 3));

        // round-robin order
        accept_log.delete();
        pend[0].push_back('{32'h3000, 3});
        pend[1].push_back('{32'h5000, 3});
        drain();
        pend[0].push_back('{32'h6000, 2});
        pend[1].push_back('{32'h7000, 2});
        drain();
        check_val("t3_accepts", DW'(accept_log.size()), DW'(4));
        if (accept_log.size() == 4) begin
            check_val("t3_first", DW'(accept_log[0]), DW'(0));
            check_val("t3_second", DW'(accept_log[1]), DW'(1));
            check_val("t3_rotate", DW'(accept_log[2]), DW'(0));
        end

        // owner back-pressure mid-burst
        rdy_pct = 100;
        pend[0].push_back('{32'h8000, 40});
        wait_beats_left(30);
        hold_rdy0 = 5;
        drain();
        rdy_pct = 75;

        // 4 KB boundary straddle (unaligned low bits are dropped)
        ar_count = 0;
        pend[0].push_back('{32'h0FC5, 2});
        drain();
        check_val("t5_ar_count", DW'(ar_count), DW'(SPLIT4K ? 2 : 1));

        // zero-length request
        ar_count = 0;
        accept_log.delete();
        pend[1].push_back('{32'h100, 0});
        drain();
        check_val("t7_zero_accepts", DW'(accept_log.size()), DW'(1));
        check_val("t7_zero_ar_count", DW'(ar_count), DW'(0));

        // error response is sticky
        err_en = 1;
        err_addr = 32'h2040;
        pend[0].push_back('{32'h2000, 4});
        drain();
        err_en = 0;
        repeat (3) cycle();
        check_val("t7_err_sticky", DW'(rresp_err), DW'(1));

        // async reset in the middle of a burst
        pend[0].push_back('{32'h10000, 40});
        wait_beats_left(35);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pend[0].push_back('{32'h400, 1});
        drain();

        // randomised traffic
        for (int batch = 0; batch < 6; batch++) begin
            ar_pct  = $urandom_range(30, 100);
            rv_pct  = $urandom_range(30, 100);
            rdy_pct = $urandom_range(30, 100);
            for (int t = 0; t < 6; t++) begin
                int r, beats;
                r = $urandom_range(0, NUM_REQ - 1);
                beats = (($urandom % 6) == 0) ? $urandom_range(257, 600) : $urandom_range(0, 70);
                pend[r].push_back('{$urandom & 32'h00FF_FFFF, beats});
            end
            drain();
        end

        finish_sim();
    end

endmodule
